dlx_instr_encoder: RTL

Streaming DLX instruction encoder and instruction-memory loader. It accepts decoded instruction fields over a valid/ready handshake, packs each into a 32-bit DLX word, and writes the words to consecutive instruction-memory addresses. The bit layout is the exact inverse of the single-cycle control decoder, so any word it writes decodes back to the same fields. It sits between the testbench/boot loader and the instruction memory write port.

---
 rtl/dlx_isa_pkg.sv | 69 ++++++
 rtl/dlx_field_pack.sv | 52 +++++
 rtl/dlx_instr_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dlx_isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : dlx_isa_pkg                                                |
// | Brief   : DLX instruction formats, opcodes, function codes, field    |
// |           bit positions and legality helpers shared by the encoder   |
// |           and the control decoder.                                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dlx_isa_pkg;

  // Instruction format carried alongside a field bundle
  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  // Field widths and bit positions (LSB of each field)
  localparam int REG_W      = 5;
  localparam int OPC_W      = 6;
  localparam int OPC_LSB    = 26;
  localparam int R_RS2_LSB  = 21;
  localparam int R_RS1_LSB  = 16;
  localparam int R_RD_LSB   = 11;
  localparam int R_FN_W     = 11;
  localparam int I_RS1_LSB  = 21;
  localparam int I_RD_LSB   = 16;
  localparam int I_IMM_W    = 16;
  localparam int J_TGT_W    = 26;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQZ    = 6'd4;
  localparam logic [5:0] OP_BNEZ    = 6'd5;
  localparam logic [5:0] OP_ADDI    = 6'd8;
  localparam logic [5:0] OP_LW      = 6'd35;
  localparam logic [5:0] OP_SW      = 6'd43;

  // R-format function codes
  localparam logic [10:0] FN_SLL = 11'd4;
  localparam logic [10:0] FN_NOP = 11'd21;
  localparam logic [10:0] FN_ADD = 11'd32;
  localparam logic [10:0] FN_SUB = 11'd34;
  localparam logic [10:0] FN_AND = 11'd36;
  localparam logic [10:0] FN_OR  = 11'd37;

  // Function codes the datapath implements
  function automatic logic fn_legal(input logic [10:0] fn);
    case (fn) inside
      11'd4, 11'd6, 11'd7, 11'd14, 11'd21, 11'd22,
      [11'd32:11'd38], [11'd40:11'd45], 11'd52, 11'd53: fn_legal = 1'b1;
      default:                                          fn_legal = 1'b0;
    endcase
  endfunction

  // I-format opcodes the datapath implements
  function automatic logic iop_legal(input logic [5:0] op);
    case (op) inside
      6'd4, 6'd5, [6'd8:6'd15], 6'd20, [6'd22:6'd29],
      6'd32, 6'd33, [6'd35:6'd37], 6'd40, 6'd41, 6'd43: iop_legal = 1'b1;
      default:                                         iop_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_field_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dlx_field_pack                                              |
// | Brief  : Combinational packer turning decoded fields into a 32-bit   |
// |          DLX word, plus a legality flag. Legality checking is only   |
// |          built when DLX_ENCODER_CHECK_EN is defined.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dlx_field_pack
  import dlx_isa_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [10:0] op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Field packing: exact inverse of the control decoder's slicing
  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {OP_SPECIAL, rs2, rs1, rd, op};
      FMT_I:   word = {op[OPC_W-1:0], rs1, rd, imm[I_IMM_W-1:0]};
      FMT_J:   word = {op[OPC_W-1:0], imm};
      default: word = '0;
    endcase
  end

`ifdef DLX_ENCODER_CHECK_EN
  // Reject illegal formats, unimplemented codes and oversized I immediates
  always_comb begin
    legal = 1'b0;
    case (fmt)
      FMT_R:   legal = fn_legal(op);
      FMT_I:   legal = iop_legal(op[OPC_W-1:0]) && (imm[25:I_IMM_W] == '0);
      FMT_J:   legal = (op[OPC_W-1:0] == OP_J) || (op[OPC_W-1:0] == OP_JAL);
      default: legal = 1'b0;
    endcase
  end
`else
  // Unchecked build: nothing is dropped; an illegal format packs as a zero word
  always_comb begin
    legal = 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/dlx_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dlx_instr_encoder                                           |
// | Brief  : Streaming DLX instruction encoder and instruction-memory    |
// |          loader. Accepts field bundles over valid/ready, packs them  |
// |          and writes them to consecutive word addresses through a     |
// |          one-entry output register.                                  |
// | Config : DLX_ENCODER_CHECK_EN enables bundle legality checking.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dlx_instr_encoder
  import dlx_isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [10:0]       in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       pk_word;
  logic              pk_legal;
  logic              accept;
  logic              write;

  dlx_field_pack u_pack (
    .fmt   (in_fmt),
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .word  (pk_word),
    .legal (pk_legal)
  );

  // Handshakes: a write frees the output register in the same cycle it can refill
  always_comb begin
    in_ready = (state_q == ST_RUN) && (!full_q || imem_ready);
    accept   = in_valid && in_ready;
    write    = full_q && imem_ready;
  end

  // Next-state logic for the FSM, output register and counters
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (write) begin
      full_d  = 1'b0;
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = base_addr;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (pk_legal) begin
            full_d  = 1'b1;
            wdata_d = pk_word;
          end else begin
            err_d = 1'b1;
          end
          if (in_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Finish on the cycle the last word leaves so done follows the write directly
        if (!full_q || write) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any pending word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      full_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Registered outputs
  always_comb begin
    imem_we    = full_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done       = done_q;
    word_count = count_q;
    err        = err_q;
  end

endmodule
`default_nettype wire
